// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment driver: glyph codes,
// code/segment widths and the active-high segment table ({a,b,c,d,e,f,g}).
package display_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned SEG_W  = 7;

    localparam logic [CODE_W-1:0] GLYPH_BLANK = 5'h10;
    localparam logic [CODE_W-1:0] GLYPH_C     = 5'h11;
    localparam logic [CODE_W-1:0] GLYPH_E     = 5'h12;
    localparam logic [CODE_W-1:0] GLYPH_L     = 5'h13;
    localparam logic [CODE_W-1:0] GLYPH_P     = 5'h14;
    localparam logic [CODE_W-1:0] GLYPH_DASH  = 5'h15;
    localparam logic [CODE_W-1:0] GLYPH_R     = 5'h16;
    localparam logic [CODE_W-1:0] GLYPH_O     = 5'h17;

    // Index = glyph code; 0x18..0x1F are reserved and render blank.
    localparam logic [SEG_W-1:0] SEG_TABLE [32] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
        7'h00, 7'h4E, 7'h4F, 7'h0E, 7'h67, 7'h01, 7'h05, 7'h1D,
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

endpackage

// File: rtl/glyph_rom.sv
// Combinational glyph code to active-high segment lookup.
module glyph_rom
    import display_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [SEG_W-1:0]  o_seg_c
);

    assign o_seg_c = SEG_TABLE[i_code];

endmodule

// File: rtl/display_multiplexado.sv
// Time-multiplexed N-digit seven-segment driver with frame-atomic code updates.
// Optional per-digit blinking is built when DISPLAY_BLINK_EN is defined.
module display_multiplexado
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [CODE_W*N_DIGITS-1:0] codes,
    input  logic                       load,
    input  logic [N_DIGITS-1:0]        blink_mask,
    output logic [SEG_W-1:0]           seg,
    output logic [N_DIGITS-1:0]        an,
    output logic                       frame_done
);

    localparam int unsigned PCNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned BUF_W  = CODE_W * N_DIGITS;

    // Inactive levels double as XOR masks that apply the pin polarity.
    localparam logic [SEG_W-1:0]    SEG_OFF = {SEG_W{ACTIVE_LOW != 0}};
    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ACTIVE_LOW != 0}};

    logic [PCNT_W-1:0]   r_pcnt,       w_pcnt_nxt;
    logic [IDX_W-1:0]    r_idx,        w_idx_nxt;
    logic [BUF_W-1:0]    r_pending,    w_pending_nxt;
    logic [BUF_W-1:0]    r_active,     w_active_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
    logic [SEG_W-1:0]    r_seg,        w_seg_nxt;
    logic [N_DIGITS-1:0] r_an,         w_an_nxt;
    logic                r_frame_done;

    logic                w_tc;
    logic                w_wrap;
    logic                w_blank;
    logic [CODE_W-1:0]   w_code;
    logic [SEG_W-1:0]    w_seg_c;
    logic [N_DIGITS-1:0] w_onehot;

    assign w_tc     = (r_pcnt == PCNT_W'(PRESCALE - 1));
    assign w_wrap   = w_tc && (r_idx == IDX_W'(N_DIGITS - 1));
    assign w_code   = CODE_W'(r_active >> (CODE_W * r_idx));
    assign w_onehot = N_DIGITS'(1) << r_idx;

    glyph_rom u_glyph_rom (
        .i_code  (w_code),
        .o_seg_c (w_seg_c)
    );

    // Scan counters, double buffer and output stage next-state.
    always_comb begin
        w_pcnt_nxt       = w_tc ? '0 : r_pcnt + PCNT_W'(1);
        w_idx_nxt        = r_idx;
        w_pending_nxt    = r_pending;
        w_active_nxt     = r_active;
        w_pend_valid_nxt = r_pend_valid;

        if (w_tc) begin
            w_idx_nxt = w_wrap ? '0 : r_idx + IDX_W'(1);
        end

        // A load landing on the boundary bypasses pending entirely.
        if (load && w_wrap) begin
            w_active_nxt     = codes;
            w_pend_valid_nxt = 1'b0;
        end else if (load) begin
            w_pending_nxt    = codes;
            w_pend_valid_nxt = 1'b1;
        end else if (w_wrap && r_pend_valid) begin
            w_active_nxt     = r_pending;
            w_pend_valid_nxt = 1'b0;
        end

        w_seg_nxt = w_blank ? SEG_OFF : (w_seg_c ^ SEG_OFF);
        w_an_nxt  = w_onehot ^ AN_OFF;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt       <= '0;
            r_idx        <= '0;
            r_pending    <= {N_DIGITS{GLYPH_BLANK}};
            r_active     <= {N_DIGITS{GLYPH_BLANK}};
            r_pend_valid <= 1'b0;
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_pcnt       <= w_pcnt_nxt;
            r_idx        <= w_idx_nxt;
            r_pending    <= w_pending_nxt;
            r_active     <= w_active_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_wrap;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int unsigned FCNT_W = $clog2(BLINK_FRAMES) + 1;

    logic [FCNT_W-1:0] r_fcnt,  w_fcnt_nxt;
    logic              r_phase, w_phase_nxt;

    // Blink phase flips once every BLINK_FRAMES frame boundaries.
    always_comb begin
        w_fcnt_nxt  = r_fcnt;
        w_phase_nxt = r_phase;
        if (w_wrap) begin
            if (r_fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                w_fcnt_nxt  = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_fcnt_nxt = r_fcnt + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_fcnt  <= w_fcnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign w_blank = r_phase & blink_mask[r_idx];
`else
    logic w_unused_blink;

    assign w_blank        = 1'b0;
    assign w_unused_blink = ^blink_mask;
`endif

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_multiplexado.sv
// Bench for display_multiplexado (N_DIGITS=4, PRESCALE=4, BLINK_FRAMES=2, ACTIVE_LOW=1).
// Honours DISPLAY_BLINK_EN the same way the design does.
module tb_display_multiplexado;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int BF = 2;
    localparam int NP = N * P;

    logic        clock;
    logic        reset_n;
    logic [19:0] codes;
    logic        load;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    display_multiplexado #(
        .N_DIGITS     (N),
        .PRESCALE     (P),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .codes      (codes),
        .load       (load),
        .blink_mask (blink_mask),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        else
            n_pass++;
    endtask

    // Active-high segments for each glyph code, written from the glyph list.
    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'h00: return 7'b1111110;  5'h01: return 7'b0110000;
            5'h02: return 7'b1101101;  5'h03: return 7'b1111001;
            5'h04: return 7'b0110011;  5'h05: return 7'b1011011;
            5'h06: return 7'b1011111;  5'h07: return 7'b1110000;
            5'h08: return 7'b1111111;  5'h09: return 7'b1111011;
            5'h0A: return 7'b1110111;  5'h0B: return 7'b0011111;
            5'h0C: return 7'b1001110;  5'h0D: return 7'b0111101;
            5'h0E: return 7'b1001111;  5'h0F: return 7'b1000111;
            5'h11: return 7'b1001110;  5'h12: return 7'b1001111;
            5'h13: return 7'b0001110;  5'h14: return 7'b1100111;
            5'h15: return 7'b0000001;  5'h16: return 7'b0000101;
            5'h17: return 7'b0011101;
            default: return 7'b0000000;
        endcase
    endfunction

    // Model: cyc counts rising edges since reset release; a load seen at
    // edge c takes effect at the first frame boundary edge (multiple of NP) >= c.
    int          cyc = 0;
    int          ld_c[$];
    logic [19:0] ld_v[$];
    logic [6:0]  exp_seg = 7'h7F;
    logic [3:0]  exp_an  = 4'hF;
    logic        exp_fd  = 1'b0;
    int          m_d;
    logic [19:0] m_act;
    logic        m_blank;

    function automatic logic [19:0] active_after(input int s);
        logic [19:0] r;
        r = {4{5'h10}};
        foreach (ld_c[i])
            if (((ld_c[i] + NP - 1) / NP) * NP <= s) r = ld_v[i];
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0;
            ld_c.delete();
            ld_v.delete();
            exp_seg = 7'h7F;
            exp_an  = 4'hF;
            exp_fd  = 1'b0;
        end else begin
            cyc++;
            if (load) begin
                ld_c.push_back(cyc);
                ld_v.push_back(codes);
            end
            m_d     = ((cyc - 1) / P) % N;
            m_act   = active_after(cyc - 1);
            m_blank = 1'b0;
`ifdef DISPLAY_BLINK_EN
            m_blank = ((((cyc - 1) / NP) / BF) % 2 == 1) && blink_mask[m_d];
`endif
            exp_seg = m_blank ? 7'h7F : ~glyph(m_act[5*m_d +: 5]);
            exp_an  = ~(4'b0001 << m_d);
            exp_fd  = (cyc % NP == 0);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("an", 32'(an), 32'(exp_an));
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    // Advance to just after rising edge n (counted from reset release).
    task automatic goto(input int n);
        int g = 0;
        while (cyc < n && g < 2000) begin
            @(posedge clock);
            #1;
            g++;
        end
        if (cyc < n) begin
            n_total++;
            $display("FAIL goto_timeout: got cyc %0d expected %0d", cyc, n);
        end
    endtask

    task automatic do_load(input int at, input logic [19:0] v);
        goto(at - 1);
        codes = v;
        load  = 1'b1;
        goto(at);
        load  = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b1;
        load       = 1'b0;
        codes      = '0;
        blink_mask = 4'b0000;
        #2 reset_n = 1'b0;
        #1 chk_en  = 1'b1;
        #19 reset_n = 1'b1;

        // Reset release and scan timing
        goto(1);
        chk("lit_reset_an", 32'(an), 32'(4'b1110));
        chk("lit_reset_seg", 32'(seg), 32'(7'b1111111));
        goto(4);  chk("lit_an_d0", 32'(an), 32'(4'b1110));
        goto(5);  chk("lit_an_d1", 32'(an), 32'(4'b1101));
        goto(9);  chk("lit_an_d2", 32'(an), 32'(4'b1011));
        goto(13); chk("lit_an_d3", 32'(an), 32'(4'b0111));
        goto(15); chk("lit_fd_pre", 32'(frame_done), 32'(1'b0));
        goto(16); chk("lit_fd_wrap", 32'(frame_done), 32'(1'b1));
        goto(17); chk("lit_fd_post", 32'(frame_done), 32'(1'b0));

        // Atomic update mid-frame
        do_load(22, {5'h10, 5'h00, 5'h11, 5'h12});
        goto(23); chk("lit_no_early_d1", 32'(seg), 32'(7'b1111111));
        goto(31); chk("lit_no_early_d3", 32'(seg), 32'(7'b1111111));
        goto(33); chk("lit_E_d0", 32'(seg), 32'(7'b0110000));
        do_load(36, {5'h01, 5'h02, 5'h03, 5'h04});
        goto(37); chk("lit_C_d1", 32'(seg), 32'(7'b0110001));
        do_load(40, {5'h16, 5'h17, 5'h14, 5'h13});
        goto(41); chk("lit_0_d2", 32'(seg), 32'(7'b0000001));
        goto(49); chk("lit_last_wins_L", 32'(seg), 32'(7'b1110001));

        // Load on the boundary edge itself
        do_load(64, {5'h15, 5'h14, 5'h13, 5'h08});
        goto(65); chk("lit_collide_8", 32'(seg), 32'(7'b0000000));
        goto(77); chk("lit_collide_dash", 32'(seg), 32'(7'b1111110));

        // Blink on digit 0
        goto(90);
        blink_mask = 4'b0001;
`ifdef DISPLAY_BLINK_EN
        goto(97);
        chk("lit_blink_seg", 32'(seg), 32'(7'b1111111));
        chk("lit_blink_an", 32'(an), 32'(4'b1110));
`endif
        goto(129); chk("lit_blink_off", 32'(seg), 32'(7'b0000000));

        // Pending load discarded by async reset mid-digit
        do_load(130, {4{5'h12}});
        goto(142);
        #2 reset_n = 1'b0;
        #1;
        chk("lit_rst_seg", 32'(seg), 32'(7'b1111111));
        chk("lit_rst_an", 32'(an), 32'(4'b1111));
        chk("lit_rst_fd", 32'(frame_done), 32'(1'b0));
        #20 reset_n = 1'b1;
        goto(5);
        chk("lit_after_rst_an", 32'(an), 32'(4'b1101));
        chk("lit_after_rst_seg", 32'(seg), 32'(7'b1111111));
        goto(40);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_multiplexado.md
# display_multiplexado

Parametrised, time-multiplexed N-digit seven-segment display driver for the coffee-machine front panel. It replaces the per-selection combinational letter decoders with one block: a shared glyph ROM, a prescaled digit scanner and double-buffered glyph codes that update atomically at frame boundaries. It also provides optional per-digit blinking. It sits between the control FSM, which supplies glyph codes, and the board's segment and anode pins.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits, 1..8.
- `PRESCALE`, 50000: clock cycles each digit stays lit, ≥2.
- `BLINK_FRAMES`, 64: frames per blink half-period, ≥1.
- `ACTIVE_LOW`, 1: 1 means `seg`/`an` are driven low-active (common anode); 0 means high-active.
- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `codes`  in  5*N_DIGITS  glyph codes; digit i occupies `codes[5*i+4:5*i]`. Digit 0 is leftmost.
- `load`  in  1  one-cycle strobe that captures `codes`.
- `blink_mask`  in  N_DIGITS  per-digit blink request.
- `seg`  out  7  segments {a,b,c,d,e,f,g}, bit 6 = a.
- `an`  out  N_DIGITS  one-hot digit enable.
- `frame_done`  out  1  one-cycle pulse at each frame wrap.

## Operation
- Glyph codes: 0x00–0x0F are hex digits 0–F.
  - 0x10 blank, 0x11 'C', 0x12 'E', 0x13 'L', 0x14 'P', 0x15 '-', 0x16 'r', 0x17 'o'.
  - 0x18–0x1F display blank.
- Active-high patterns include:
  - '0' = 1111110, '1' = 0110000, '8' = 1111111.
  - 'C' = 1001110, 'E' = 1001111, '-' = 0000001, blank = 0000000.
- Polarity: output levels are inverted when `ACTIVE_LOW` = 1. The inactive level is all-ones when `ACTIVE_LOW` = 1, all-zeros otherwise.
- Prescaler `pcnt` (width clog2(PRESCALE)) counts 0..PRESCALE-1 and then wraps. Terminal count (`tc`) occurs when `pcnt` = PRESCALE-1.
- Digit index `idx` (width max(1, clog2(N_DIGITS))) increments on `tc` and wraps from N_DIGITS-1 to 0. That wrap is the frame boundary.
- Buffers:
  - `pending` register plus `pend_valid` flag.
  - `active` register, which is what gets displayed.
- `load` copies `codes` into `pending` and sets `pend_valid`. A second `load` before the boundary overwrites `pending`; the last load wins.
- At a frame boundary with `pend_valid` = 1: `active` ← `pending`, and `pend_valid` clears.
- If `load` coincides with the boundary cycle, `codes` goes directly into `active` and `pend_valid` ends at 0.
- Output stage: `an` = one-hot(`idx`) and `seg` = rom(`active[idx]`), both registered.
- There is no FSM beyond the scan counter; the state is {`pcnt`, `idx`, `pend_valid`, blink phase}.

## Timing
- Reset (async assert, sync-safe deassert on the next `clock`):
  - `pcnt` = 0, `idx` = 0.
  - `active` = all 0x10 (blank), `pend_valid` = 0.
  - `seg` and `an` at the inactive level, `frame_done` = 0, blink phase = 0.
- First cycle after reset: `an` selects digit 0 with blank segments.
- Digit dwell is exactly PRESCALE cycles. The frame period is N_DIGITS*PRESCALE cycles.
- `seg`/`an` change 1 cycle after the `idx` change; both always change in the same cycle, so there is no ghosting skew.
- `frame_done` is high for the single cycle after the `idx` wrap. With N_DIGITS = 1 it pulses every PRESCALE cycles.
- Load latency: the new glyph appears at most one frame plus 1 cycle after `load`.
- Reset mid-frame discards `pending` and `active`.

## Configuration
- `DISPLAY_BLINK_EN` defined:
  - A frame counter of width clog2(BLINK_FRAMES)+1 toggles the blink phase every BLINK_FRAMES frame boundaries.
  - When phase = 1 and `blink_mask[idx]` = 1, `seg` is forced to the inactive level while `an` still scans.
  - `blink_mask` is sampled combinationally into the output register.
- Undefined: `blink_mask` is present but ignored, no blink logic is synthesised, and `seg` is never forced blank.

## Structure
- Package `display_pkg` holds:
  - glyph code localparams (`GLYPH_BLANK`, `GLYPH_C`, …);
  - the 5-bit code width constant;
  - the 32-entry active-high segment table.
- One sub-module, `glyph_rom`: combinational 5-bit code to 7-bit active-high segments. Polarity is applied in the top level.

## Test plan
- Reset/idle: hold `reset_n` = 0, then release. `an` = 4'b1110 and `seg` = 7'b1111111 (ACTIVE_LOW = 1). `frame_done` = 0 until cycle 4*PRESCALE.
- Scan timing (PRESCALE = 4): `an` cycles 1110→1101→1011→0111 every 4 cycles. `frame_done` pulses every 16 cycles.
- Atomic update: `load` codes {0x12, 0x11, 0x00, 0x10} mid-frame. No digit changes before the next `frame_done`. After it, digit 0 shows `seg` = ~1001111 ('E') and digit 1 shows ~1001110 ('C').
- Load collision: assert `load` exactly on the boundary cycle. The new codes are displayed in that same frame and `pend_valid` = 0.
- Blink (`DISPLAY_BLINK_EN`, BLINK_FRAMES = 2, `blink_mask` = 4'b0001): digit 0 segments are blank in frames 2–3 and 6–7 while `an` still selects it. Other digits are unaffected.
- Async reset asserted mid-digit: `seg`/`an` go inactive immediately. After release, a prior `load` has no effect and all digits are blank.
